serial_tx_arbiter: RTL and testbench

//  Shares the single serial transmitter (new_data/data/busy byte handshake) between NUM_REQ

---
 rtl/serial_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin, packet-atomic arbiter sharing one serial TX byte port
// Optional forced-release timeout enabled by defining TX_ARB_TIMEOUT_EN.
module serial_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     new_data_in,
    input  logic [8*NUM_REQ-1:0]   data_in,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     busy_out,
    input  logic                   busy,
    output logic                   new_data_tx,
    output logic [7:0]             data_tx,
    output logic                   drop_err,
    output logic                   timeout
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               pend_q, pend_d;
    logic               new_data_tx_q, new_data_tx_d;
    logic [7:0]         data_tx_q, data_tx_d;
    logic               drop_err_q, drop_err_d;
    logic               timeout_q, timeout_d;
    logic [NUM_REQ-1:0] req_eff;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   winner;
    logic               found;
    logic               fwd;

`ifdef TX_ARB_TIMEOUT_EN
    logic [15:0]        idle_cnt_q, idle_cnt_d;
    logic [NUM_REQ-1:0] stale_q, stale_d;
    // A requester forced off stays masked until it has let go of req once.
    assign req_eff = req & ~stale_q;
`else
    logic unused_hold;
    assign unused_hold = (HOLD_TIMEOUT > 0);
    assign req_eff     = req;
`endif

    assign busy_out = ~gnt_q | {NUM_REQ{busy | pend_q}};
    assign fwd      = (state_q == OWN) && new_data_in[rr_ptr_q] && !busy_out[rr_ptr_q];

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        rr_ptr_d      = rr_ptr_q;
        pend_d        = fwd;
        new_data_tx_d = fwd;
        data_tx_d     = fwd ? data_in[int'(rr_ptr_q)*8 +: 8] : data_tx_q;
        drop_err_d    = drop_err_q | (|(new_data_in & busy_out));
        timeout_d     = 1'b0;
        cand          = '0;
        winner        = '0;
        found         = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
        idle_cnt_d    = idle_cnt_q;
        stale_d       = stale_q & req;
`endif
        // Search starts just past the last owner, so the last owner goes to the back.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && req_eff[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        case (state_q)
            IDLE: begin
                gnt_d = '0;
`ifdef TX_ARB_TIMEOUT_EN
                idle_cnt_d = '0;
`endif
                if (found) begin
                    gnt_d[winner] = 1'b1;
                    rr_ptr_d      = winner;
                    state_d       = OWN;
                end
            end
            OWN: begin
                if (!req[rr_ptr_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
`ifdef TX_ARB_TIMEOUT_EN
                else if (fwd) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == 16'(HOLD_TIMEOUT - 1)) begin
                    state_d           = IDLE;
                    gnt_d             = '0;
                    timeout_d         = 1'b1;
                    stale_d[rr_ptr_q] = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            rr_ptr_q      <= PTR_W'(NUM_REQ - 1);
            pend_q        <= 1'b0;
            new_data_tx_q <= 1'b0;
            data_tx_q     <= 8'h00;
            drop_err_q    <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
            idle_cnt_q    <= '0;
            stale_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rr_ptr_q      <= rr_ptr_d;
            pend_q        <= pend_d;
            new_data_tx_q <= new_data_tx_d;
            data_tx_q     <= data_tx_d;
            drop_err_q    <= drop_err_d;
            timeout_q     <= timeout_d;
`ifdef TX_ARB_TIMEOUT_EN
            idle_cnt_q    <= idle_cnt_d;
            stale_q       <= stale_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign new_data_tx = new_data_tx_q;
    assign data_tx     = data_tx_q;
    assign drop_err    = drop_err_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - directed self-checking bench for serial_tx_arbiter
module tb_serial_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  new_data_in;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic [3:0]  busy_out;
    logic        busy;
    logic        new_data_tx;
    logic [7:0]  data_tx;
    logic        drop_err;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    serial_tx_arbiter #(.NUM_REQ(4), .HOLD_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .new_data_in (new_data_in),
        .data_in     (data_in),
        .gnt         (gnt),
        .busy_out    (busy_out),
        .busy        (busy),
        .new_data_tx (new_data_tx),
        .data_tx     (data_tx),
        .drop_err    (drop_err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] exp_gnt [5];
    logic [7:0] exp_byte [5];

    initial begin
        rst = 1'b1; req = '0; new_data_in = '0; busy = 1'b0;
        data_in = {8'h13, 8'h12, 8'h11, 8'h10};
        exp_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_byte = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();

        check("rst_gnt", gnt, 4'b0000);
        check("rst_ndtx", new_data_tx, 1'b0);
        check("rst_data", data_tx, 8'h00);
        check("rst_drop", drop_err, 1'b0);
        check("rst_tmo", timeout, 1'b0);
        check("rst_busy_out", busy_out, 4'b1111);

        // 1: single requester, one byte
        data_in[7:0] = 8'hA5;
        req = 4'b0001;
        tick();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_busy_out", busy_out, 4'b1110);
        new_data_in = 4'b0001;
        tick();
        new_data_in = '0;
        check("t1_ndtx", new_data_tx, 1'b1);
        check("t1_data", data_tx, 8'hA5);
        check("t1_pend", busy_out, 4'b1111);
        tick();
        check("t1_ndtx_low", new_data_tx, 1'b0);
        check("t1_data_hold", data_tx, 8'hA5);
        check("t1_busy_out2", busy_out, 4'b1110);
        req = '0;
        tick();
        check("t1_release", gnt, 4'b0000);
        check("t1_drop", drop_err, 1'b0);
        tick();

        // 2: all four request, each sends one byte and drops req in the strobe cycle
        do_reset();
        data_in = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t2_gnt%0d", k), gnt, exp_gnt[k]);
            new_data_in = exp_gnt[k];
            req = 4'b1111 & ~exp_gnt[k];
            tick();
            check($sformatf("t2_gap%0d", k), gnt, 4'b0000);
            check($sformatf("t2_ndtx%0d", k), new_data_tx, 1'b1);
            check($sformatf("t2_data%0d", k), data_tx, exp_byte[k]);
            new_data_in = '0;
            req = 4'b1111;
        end
        req = '0;
        tick();
        tick();
        check("t2_drop", drop_err, 1'b0);

        // 3: back-to-back strobes, second hits the pend window
        do_reset();
        req = 4'b0010;
        tick();
        check("t3_gnt", gnt, 4'b0010);
        new_data_in = 4'b0010;
        tick();
        check("t3_ndtx1", new_data_tx, 1'b1);
        check("t3_data1", data_tx, 8'h11);
        data_in[15:8] = 8'h22;
        tick();
        new_data_in = '0;
        check("t3_ndtx2", new_data_tx, 1'b0);
        check("t3_data2", data_tx, 8'h11);
        check("t3_drop", drop_err, 1'b1);
        req = '0;
        tick();
        tick();

        // 4: ungranted strobe, then busy holds the grant
        do_reset();
        req = 4'b0001;
        tick();
        check("t4_gnt", gnt, 4'b0001);
        new_data_in = 4'b0100;
        tick();
        new_data_in = '0;
        check("t4_ndtx", new_data_tx, 1'b0);
        check("t4_drop", drop_err, 1'b1);
        check("t4_gnt_keep", gnt, 4'b0001);
        busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t4_busy_gnt%0d", k), gnt, 4'b0001);
            check($sformatf("t4_busy_out%0d", k), busy_out, 4'b1111);
        end

        // 6: reset mid-packet with busy high
        new_data_in = 4'b0001;
        rst = 1'b1;
        req = 4'b1111;
        tick();
        new_data_in = '0;
        check("t6_gnt", gnt, 4'b0000);
        check("t6_ndtx", new_data_tx, 1'b0);
        check("t6_drop", drop_err, 1'b0);
        rst = 1'b0;
        busy = 1'b0;
        tick();
        check("t6_restart", gnt, 4'b0001);
        req = '0;
        tick();
        tick();

`ifdef TX_ARB_TIMEOUT_EN
        // 5: forced release after 16 idle owned cycles
        do_reset();
        req = 4'b1000;
        tick();
        check("t5_gnt", gnt, 4'b1000);
        for (int k = 1; k < 16; k++) begin
            tick();
            check($sformatf("t5_hold%0d", k), {timeout, gnt}, {1'b0, 4'b1000});
        end
        tick();
        check("t5_tmo", timeout, 1'b1);
        check("t5_gnt0", gnt, 4'b0000);
        tick();
        check("t5_tmo_pulse", timeout, 1'b0);
        tick();
        tick();
        check("t5_masked", gnt, 4'b0000);
        req = '0;
        tick();
        req = 4'b1000;
        tick();
        check("t5_regrant", gnt, 4'b1000);
        req = '0;
        tick();
`else
        check("t5_tmo_tied", timeout, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
